// File: rtl/memory_bus_arbiter_pkg.sv
// Shared widths, arbiter state encodings and small helpers for the memory bus arbiter.
package memory_bus_arbiter_pkg;

    localparam int AddressBusWidth = 32;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_OWN_I = 2'd1,
        ARB_OWN_D = 2'd2,
        ARB_TURN  = 2'd3
    } arb_state_t;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/arb_beat_address_gen.sv
// Holds the word-aligned line base and beat count; emits the wrapped,
// critical-word-first beat address and a last-beat flag.
module arb_beat_address_gen
    import memory_bus_arbiter_pkg::*;
#(
    parameter int BurstLength = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       load,
    input  logic [AddressBusWidth-1:0] start_address,
    input  logic                       advance,
    output logic [AddressBusWidth-1:0] beat_address,
    output logic                       last_beat
);

    localparam int CountWidth = clog2_min1(BurstLength);
    localparam int LineBits   = $clog2(BurstLength) + 2;
    localparam logic [AddressBusWidth-1:0] WordMask = ~AddressBusWidth'(3);

    logic [AddressBusWidth-1:0] base;
    logic [CountWidth-1:0]      count;

    always_ff @(posedge clock) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (advance) begin
            count <= count + CountWidth'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (load) begin
            base <= start_address & WordMask;
        end
    end

    assign last_beat = (count == CountWidth'(BurstLength - 1));

    generate
        if (BurstLength == 1) begin : g_single
            assign beat_address = base;
        end else begin : g_wrap
            // The word offset wraps modulo the burst, staying inside the aligned line.
            logic [LineBits-3:0] offset;
            assign offset       = base[LineBits-1:2] + count;
            assign beat_address = {base[AddressBusWidth-1:LineBits], offset, base[1:0]};
        end
    endgenerate

endmodule

// File: rtl/memory_bus_arbiter.sv
// Arbitrates the single memory controller port between the I and D cache
// controllers and sequences one fixed-length line burst per grant.
module memory_bus_arbiter
    import memory_bus_arbiter_pkg::*;
#(
    parameter int BurstLength = 4,
    parameter int StarveLimit = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       IRequest,
    input  logic [AddressBusWidth-1:0] IAddress,
    output logic                       IGrant,
    output logic                       IBeat,
    output logic                       IDone,
    input  logic                       DRequest,
    input  logic [AddressBusWidth-1:0] DAddress,
    input  logic                       DWrite,
    output logic                       DGrant,
    output logic                       DBeat,
    output logic                       DDone,
    output logic [AddressBusWidth-1:0] MemoryAddress,
    output logic                       MemoryRequest,
    output logic                       MemoryWrite,
    input  logic                       nMemoryWait
);

    localparam int StarveWidth = $clog2(StarveLimit + 2);
    localparam logic [StarveWidth-1:0] StarveMax = StarveWidth'(StarveLimit);

    arb_state_t                 state, next_state;
    logic [StarveWidth-1:0]     starve_count;
    logic                       dwrite_latched;
    logic                       grant_i, grant_d;
    logic                       load, advance, last_beat;
    logic [AddressBusWidth-1:0] load_address, beat_address;

    arb_beat_address_gen #(
        .BurstLength (BurstLength)
    ) u_addr_gen (
        .clock         (clock),
        .reset         (reset),
        .load          (load),
        .start_address (load_address),
        .advance       (advance),
        .beat_address  (beat_address),
        .last_beat     (last_beat)
    );

    always_comb begin
        next_state    = state;
        grant_i       = 1'b0;
        grant_d       = 1'b0;
        load          = 1'b0;
        load_address  = IAddress;
        advance       = 1'b0;
        IGrant        = 1'b0;
        IBeat         = 1'b0;
        IDone         = 1'b0;
        DGrant        = 1'b0;
        DBeat         = 1'b0;
        DDone         = 1'b0;
        MemoryRequest = 1'b0;
        MemoryWrite   = 1'b0;
        case (state)
            ARB_IDLE: begin
                // D is favoured until I has watched StarveLimit D grants go by.
                if (DRequest && (!IRequest || starve_count < StarveMax)) begin
                    grant_d      = 1'b1;
                    load         = 1'b1;
                    load_address = DAddress;
                    next_state   = ARB_OWN_D;
                end else if (IRequest) begin
                    grant_i    = 1'b1;
                    load       = 1'b1;
                    next_state = ARB_OWN_I;
                end
            end
            ARB_OWN_I: begin
                IGrant        = 1'b1;
                MemoryRequest = 1'b1;
                IBeat         = nMemoryWait;
                advance       = nMemoryWait;
                IDone         = nMemoryWait && last_beat && IRequest;
                if (!IRequest || IDone) next_state = ARB_TURN;
            end
            ARB_OWN_D: begin
                DGrant        = 1'b1;
                MemoryRequest = 1'b1;
                MemoryWrite   = dwrite_latched;
                DBeat         = nMemoryWait;
                advance       = nMemoryWait;
                DDone         = nMemoryWait && last_beat && DRequest;
                if (!DRequest || DDone) next_state = ARB_TURN;
            end
            ARB_TURN: next_state = ARB_IDLE;
            default:  next_state = ARB_IDLE;
        endcase
    end

    assign MemoryAddress = MemoryRequest ? beat_address : '0;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state          <= ARB_IDLE;
            starve_count   <= '0;
            dwrite_latched <= 1'b0;
        end else begin
            state <= next_state;
            if (grant_i) begin
                starve_count <= '0;
            end else if (grant_d && IRequest && starve_count < StarveMax) begin
                starve_count <= starve_count + StarveWidth'(1);
            end
            if (grant_d) dwrite_latched <= DWrite;
        end
    end

endmodule
